// File: rtl/tau_transform_pipe_pkg.sv
// Shared constants, the SM4 S-box table and the SM4 linear transforms
// (L for enc/dec, L' for key expansion) used by the tau pipeline.
package tau_transform_pipe_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;

  localparam int unsigned ROT_L_A = 2;
  localparam int unsigned ROT_L_B = 10;
  localparam int unsigned ROT_L_C = 18;
  localparam int unsigned ROT_L_D = 24;
  localparam int unsigned ROT_K_A = 13;
  localparam int unsigned ROT_K_B = 23;

  typedef enum logic {
    L_ENC = 1'b0,
    L_KEY = 1'b1
  } l_sel_e;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [WORD_WIDTH-1:0] rotl(input logic [WORD_WIDTH-1:0] w,
                                                 input int unsigned n);
    return (w << n) | (w >> (WORD_WIDTH - n));
  endfunction

  function automatic logic [WORD_WIDTH-1:0] l_enc(input logic [WORD_WIDTH-1:0] b);
    return b ^ rotl(b, ROT_L_A) ^ rotl(b, ROT_L_B) ^ rotl(b, ROT_L_C) ^ rotl(b, ROT_L_D);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] l_key(input logic [WORD_WIDTH-1:0] b);
    return b ^ rotl(b, ROT_K_A) ^ rotl(b, ROT_K_B);
  endfunction

endpackage

// File: rtl/tau_transform_pipe_lane.sv
// One 32-bit lane: four S-box byte substitutions and, when TAU_L_FUSE_EN
// is defined, the selectable L / L' linear transform on a separate input.

module sbox_replace
  import tau_transform_pipe_pkg::*;
(
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [BYTE_WIDTH-1:0] byte_out
);

  assign byte_out = SBOX_TABLE[byte_in];

endmodule

module tau_lane
  import tau_transform_pipe_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_tau
`ifdef TAU_L_FUSE_EN
  ,
  input  logic                  l_mode,
  input  logic [WORD_WIDTH-1:0] l_in,
  output logic [WORD_WIDTH-1:0] l_out
`endif
);

  for (genvar b = 0; b < WORD_WIDTH / BYTE_WIDTH; b++) begin : g_byte
    sbox_replace u_sbox (
      .byte_in  (word_in[b*BYTE_WIDTH +: BYTE_WIDTH]),
      .byte_out (word_tau[b*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

`ifdef TAU_L_FUSE_EN
  // L input is a separate port so the top can place it at either pipe end
  assign l_out = (l_sel_e'(l_mode) == L_KEY) ? l_key(l_in) : l_enc(l_in);
`endif

endmodule

// File: rtl/tau_transform_pipe.sv
// SM4 tau (byte S-box) pipeline with valid/ready handshake and flush.
// Define TAU_L_FUSE_EN to fuse the L / L' linear transform into the pipe.

module tau_transform_pipe
  import tau_transform_pipe_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int STAGES    = 1,
  parameter int TAG_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic [WORD_WIDTH*LANES-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [WORD_WIDTH*LANES-1:0]   out_data
);

  localparam int DW = WORD_WIDTH * LANES;

  logic [STAGES-1:0]    slot_valid;
  logic [STAGES-1:0]    slot_mode;
  logic [TAG_WIDTH-1:0] slot_tag  [STAGES];
  logic [DW-1:0]        slot_data [STAGES];

  logic [STAGES-1:0]    slot_load;
  logic [STAGES-1:0]    stage_valid;
  logic [STAGES-1:0]    stage_mode;
  logic [TAG_WIDTH-1:0] stage_tag  [STAGES];
  logic [DW-1:0]        stage_data [STAGES];

  logic [DW-1:0]        tau_data;
  logic [DW-1:0]        head_data;
  logic                 unused_mode;

`ifdef TAU_L_FUSE_EN
  logic [DW-1:0]        l_in_data;
  logic [DW-1:0]        l_out_data;
  logic                 l_mode_sel;

  // Single stage: L sits in front of slot 0; otherwise between the last two slots
  if (STAGES == 1) begin : g_l_head
    assign l_in_data  = tau_data;
    assign l_mode_sel = in_mode;
    assign head_data  = l_out_data;
  end else begin : g_l_tail
    assign l_in_data  = slot_data[STAGES-2];
    assign l_mode_sel = slot_mode[STAGES-2];
    assign head_data  = tau_data;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tau_lane u_lane (
      .word_in  (in_data[k*WORD_WIDTH +: WORD_WIDTH]),
      .word_tau (tau_data[k*WORD_WIDTH +: WORD_WIDTH]),
      .l_mode   (l_mode_sel),
      .l_in     (l_in_data[k*WORD_WIDTH +: WORD_WIDTH]),
      .l_out    (l_out_data[k*WORD_WIDTH +: WORD_WIDTH])
    );
  end
`else
  assign head_data = tau_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tau_lane u_lane (
      .word_in  (in_data[k*WORD_WIDTH +: WORD_WIDTH]),
      .word_tau (tau_data[k*WORD_WIDTH +: WORD_WIDTH])
    );
  end
`endif

  // A slot may load when any slot from it to the output is empty, or output drains
  always_comb begin
    slot_load = '0;
    for (int i = 0; i < STAGES; i++) begin
      slot_load[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!slot_valid[j]) slot_load[i] = 1'b1;
      end
    end
  end

  assign in_ready = !rst && !flush && slot_load[0];

  always_comb begin
    stage_valid   = '0;
    stage_mode    = '0;
    stage_valid[0] = in_valid && in_ready;
    stage_mode[0]  = in_mode;
    stage_tag[0]   = in_tag;
    stage_data[0]  = head_data;
    for (int i = 1; i < STAGES; i++) begin
      stage_valid[i] = slot_valid[i-1];
      stage_mode[i]  = slot_mode[i-1];
      stage_tag[i]   = slot_tag[i-1];
      stage_data[i]  = slot_data[i-1];
    end
`ifdef TAU_L_FUSE_EN
    if (STAGES >= 2) stage_data[STAGES-1] = l_out_data;
`endif
  end

  // Payload only loads alongside a valid beat so a stalled output stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      slot_mode  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else if (flush) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (slot_load[i]) begin
          slot_valid[i] <= stage_valid[i];
          if (stage_valid[i]) begin
            slot_mode[i] <= stage_mode[i];
            slot_tag[i]  <= stage_tag[i];
            slot_data[i] <= stage_data[i];
          end
        end
      end
    end
  end

  assign unused_mode = ^slot_mode;

  assign out_valid = slot_valid[STAGES-1];
  assign out_tag   = slot_tag[STAGES-1];
  assign out_data  = slot_data[STAGES-1];

endmodule

// File: tb/tb_tau_transform_pipe.sv
// Self-checking bench for tau_transform_pipe (LANES=4, STAGES=3): directed
// vectors with literal expectations plus a per-cycle scoreboard model.

module tb_tau_transform_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 3;
  localparam int TAGW   = 4;
  localparam int DW     = 32 * LANES;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_mode = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [TAGW-1:0] out_tag;
  logic [DW-1:0]   out_data;

  int tests = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  tau_transform_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_WIDTH(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data)
  );

  logic [7:0] sbox_tb [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] model_tau(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_tb[w[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] rot(input logic [31:0] w, input int n);
    logic [63:0] d;
    d = {w, w} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w, input logic mode);
    logic [31:0] b;
    b = model_tau(w);
`ifdef TAU_L_FUSE_EN
    if (mode) return b ^ rot(b, 13) ^ rot(b, 23);
    return b ^ rot(b, 2) ^ rot(b, 10) ^ rot(b, 18) ^ rot(b, 24);
`else
    if (mode) return b;
    return b;
`endif
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic mode);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[32*k +: 32] = model_word(d[32*k +: 32], mode);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [TAGW-1:0] t,
                               input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_mode   = m;
    in_tag    = t;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int              stamp;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
  } beat_t;

  beat_t sb[$];

  // Scoreboard: in-flight beats in order; the oldest is visible STAGES cycles after acceptance
  always @(negedge clk) begin
    logic  exp_ready;
    logic  exp_ov;
    beat_t nb;
    cyc++;
    if (rst) begin
      sb.delete();
      checkOutput("rst_out_valid", DW'(out_valid), '0);
      checkOutput("rst_out_data", out_data, '0);
      checkOutput("rst_out_tag", DW'(out_tag), '0);
      checkOutput("rst_in_ready", DW'(in_ready), '0);
    end else begin
      exp_ready = !flush && ((sb.size() < STAGES) || out_ready);
      exp_ov    = (sb.size() > 0) && (cyc >= sb[0].stamp + STAGES);
      checkOutput("in_ready", DW'(in_ready), DW'(exp_ready));
      checkOutput("out_valid", DW'(out_valid), DW'(exp_ov));
      if (exp_ov) begin
        checkOutput("out_data", out_data, sb[0].data);
        checkOutput("out_tag", DW'(out_tag), DW'(sb[0].tag));
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_ov && out_ready) void'(sb.pop_front());
        if (in_valid && exp_ready) begin
          nb.stamp = cyc;
          nb.tag   = in_tag;
          nb.data  = model_beat(in_data, in_mode);
          sb.push_back(nb);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            wcount;
    int            seen;
    logic [TAGW-1:0] tags [3];
    logic [DW-1:0] exp1;

    checkOutput("pin_tau_zero", DW'(model_tau(32'h00000000)), DW'(32'hD6D6D6D6));
    checkOutput("pin_tau_0102", DW'(model_tau(32'h00010203)), DW'(32'hD690E9FE));
    checkOutput("pin_tau_ff", DW'(model_tau(32'h000000FF)), DW'(32'hD6D6D648));
    checkOutput("pin_tau_01", DW'(model_tau(32'h01010101)), DW'(32'h90909090));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_rst", DW'(in_ready), DW'(1'b1));
    @(posedge clk);
    #1;

    // Literal tau vectors, back-to-back
    applyStimulus(1'b1, 1'b0, 4'd1, {32'h0, 32'h0, 32'h01010101, 32'h000000FF}, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd2, {32'h0, 32'h0, 32'h0, 32'h00000000}, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, {32'h0, 32'h0, 32'h0, 32'h00010203}, 1'b1, 1'b0);
    in_valid = 1'b0;
    wcount = 0;
    do begin
      @(negedge clk);
      wcount++;
    end while (!out_valid && wcount < 10);
    checkOutput("burst_latency", DW'(wcount), DW'(1));
`ifndef TAU_L_FUSE_EN
    checkOutput("lit_lanes", out_data, {32'hD6D6D6D6, 32'hD6D6D6D6, 32'h90909090, 32'hD6D6D648});
    @(negedge clk);
    checkOutput("lit_zero", out_data, {4{32'hD6D6D6D6}});
    @(negedge clk);
    checkOutput("lit_0102", out_data, {32'hD6D6D6D6, 32'hD6D6D6D6, 32'hD6D6D6D6, 32'hD690E9FE});
`else
    exp1 = model_beat({32'h0, 32'h0, 32'h01010101, 32'h000000FF}, 1'b0);
    checkOutput("fused_lanes", out_data, exp1);
    @(negedge clk);
    @(negedge clk);
`endif
    @(posedge clk);
    #1;

    // Backpressure: three beats fill the pipe, then in_ready drops
    applyStimulus(1'b1, 1'b0, 4'd1, {4{32'h11223344}}, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd2, {4{32'h55667788}}, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, {4{32'h99AABBCC}}, 1'b0, 1'b0);
    in_tag = 4'd4;
    @(negedge clk);
    checkOutput("full_in_ready", DW'(in_ready), DW'(1'b0));
    checkOutput("stall_tag", DW'(out_tag), DW'(4'd1));
    @(negedge clk);
    checkOutput("stall_hold_tag", DW'(out_tag), DW'(4'd1));
    checkOutput("stall_hold_valid", DW'(out_valid), DW'(1'b1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    wcount = 0;
    while (seen < 3 && wcount < 10) begin
      @(negedge clk);
      wcount++;
      if (out_valid) begin
        tags[seen] = out_tag;
        seen++;
      end
    end
    checkOutput("drain_count", DW'(seen), DW'(3));
    checkOutput("drain_tag0", DW'(tags[0]), DW'(4'd1));
    checkOutput("drain_tag1", DW'(tags[1]), DW'(4'd2));
    checkOutput("drain_tag2", DW'(tags[2]), DW'(4'd3));
    @(posedge clk);
    #1;

    // Flush with two beats in flight and a concurrent input beat
    applyStimulus(1'b1, 1'b0, 4'd5, {4{32'hCAFEF00D}}, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd6, {4{32'hDEADBEEF}}, 1'b1, 1'b0);
    in_tag = 4'd7;
    flush  = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", DW'(in_ready), DW'(1'b0));
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("flush_no_output", DW'(seen), DW'(0));
    @(posedge clk);
    #1;

    // Reset mid-stream, then a fresh beat
    applyStimulus(1'b1, 1'b0, 4'd8, {4{32'h01234567}}, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd9, {4{32'h89ABCDEF}}, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd10, {4{32'hF0E1D2C3}}, 1'b1, 1'b0);
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", DW'(out_valid), DW'(1'b1));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", DW'(out_valid), DW'(1'b0));
    checkOutput("mid_rst_data", out_data, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd11, {4{32'h00000000}}, 1'b1, 1'b0);
    in_valid = 1'b0;
    wcount = 0;
    do begin
      @(negedge clk);
      wcount++;
    end while (!out_valid && wcount < 10);
    checkOutput("post_rst_latency", DW'(wcount), DW'(STAGES));
    checkOutput("post_rst_tag", DW'(out_tag), DW'(4'd11));
    @(posedge clk);
    #1;

    // Mixed modes, random stalls and gaps
    for (int n = 0; n < 120; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 3) != 0), 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("end_idle_valid", DW'(out_valid), DW'(1'b0));
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
